// File: rtl/lfsr_checker.sv
// -----------------------------------------------------------------------------
// lfsr_checker
//
// Serial receiver for the 3-bit Fibonacci LFSR pattern source. It acquires the
// generator's x0 stream and self-synchronises to it. Once locked it flywheels
// its own prediction, flagging and counting every mismatching bit.
//
// Parameters
//   LOCK_CNT  consecutive correct predictions needed to declare lock (1..255)
//   FAIL_LIM  consecutive mismatches while locked that drop lock (1..15)
//   CW        width of Err_cnt / Bit_cnt
//
// Ports
//   CLK      clock, rising edge
//   RST      asynchronous active-low reset
//   Poly     polynomial select: 0 -> b[n+3]=b[n+2]^b[n], 1 -> b[n+3]=b[n+1]^b[n]
//   En       Din is valid this cycle
//   Din      received serial bit
//   Clr      synchronous clear of Err_cnt and Bit_cnt
//   Locked   high while in LOCKED
//   Err      one-cycle pulse after a mismatching bit is checked in LOCKED
//   Err_cnt  saturating count of mismatches seen in LOCKED
//   Bit_cnt  saturating count of bits checked in LOCKED
// -----------------------------------------------------------------------------
module lfsr_checker #(
  parameter int LOCK_CNT = 7,
  parameter int FAIL_LIM = 3,
  parameter int CW       = 16
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          Poly,
  input  logic          En,
  input  logic          Din,
  input  logic          Clr,
  output logic          Locked,
  output logic          Err,
  output logic [CW-1:0] Err_cnt,
  output logic [CW-1:0] Bit_cnt
);

  typedef enum logic [1:0] {
    ST_ACQ    = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    hist_q, hist_d;      // [2] newest .. [0] oldest
  logic [1:0]    fill_q, fill_d;
  logic [7:0]    match_q, match_d;
  logic [3:0]    fail_q, fail_d;
  logic          poly_q;
  logic          err_q, err_d;
  logic [CW-1:0] err_cnt_q, err_cnt_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;

  logic          pred;
  logic          mism;
  logic          poly_chg;
  logic          err_inc;
  logic          bit_inc;
  logic [2:0]    shift_din;

  // Poly is compared against its registered copy, so a change is seen on the
  // very edge it is first registered.
  assign poly_chg  = Poly != poly_q;
  assign pred      = poly_q ? (hist_q[1] ^ hist_q[0]) : (hist_q[2] ^ hist_q[0]);
  assign mism      = Din ^ pred;
  assign shift_din = {Din, hist_q[2:1]};

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case/if tree can leave one unassigned and infer a latch.
    state_d   = state_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    match_d   = match_q;
    fail_d    = fail_q;
    err_d     = 1'b0;
    err_inc   = 1'b0;
    bit_inc   = 1'b0;
    err_cnt_d = err_cnt_q;
    bit_cnt_d = bit_cnt_q;

    if (poly_chg) begin
      // The history was built under the old rule; start over regardless of En.
      state_d = ST_ACQ;
      hist_d  = 3'b000;
      fill_d  = 2'd0;
    end else if (En) begin
      unique case (state_q)
        ST_ACQ: begin
          hist_d = shift_din;
          if (fill_q == 2'd2) begin
            fill_d = 2'd0;
            // An all-zero history is the LFSR lock-up state; keep filling.
            if (shift_din != 3'b000) begin
              state_d = ST_VERIFY;
              match_d = 8'd0;
            end
          end else begin
            fill_d = fill_q + 2'd1;
          end
        end

        ST_VERIFY: begin
          // Received bits feed the history so a wrong start self-corrects.
          hist_d  = shift_din;
          match_d = mism ? 8'd0 : match_q + 8'd1;
          if (shift_din == 3'b000) begin
            state_d = ST_ACQ;
            fill_d  = 2'd0;
          end else if (!mism && match_q == 8'(LOCK_CNT - 1)) begin
            state_d = ST_LOCKED;
            fail_d  = 4'd0;
          end
        end

        ST_LOCKED: begin
          // Flywheel: our own prediction feeds the history, so one corrupted
          // bit produces exactly one error instead of a burst.
          hist_d  = {pred, hist_q[2:1]};
          bit_inc = 1'b1;
          if (mism) begin
            err_d   = 1'b1;
            err_inc = 1'b1;
            fail_d  = fail_q + 4'd1;
            if (fail_q == 4'(FAIL_LIM - 1)) begin
              state_d = ST_ACQ;
              hist_d  = 3'b000;
              fill_d  = 2'd0;
            end
          end else begin
            fail_d = 4'd0;
          end
        end

        default: begin
          state_d = ST_ACQ;
          hist_d  = 3'b000;
          fill_d  = 2'd0;
        end
      endcase
    end

    // Clear wins over a same-edge increment; counts stick at all-ones.
    if (Clr) begin
      err_cnt_d = '0;
      bit_cnt_d = '0;
    end else begin
      if (err_inc && !(&err_cnt_q)) err_cnt_d = err_cnt_q + CW'(1);
      if (bit_inc && !(&bit_cnt_q)) bit_cnt_d = bit_cnt_q + CW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= ST_ACQ;
      hist_q    <= 3'b000;
      fill_q    <= 2'd0;
      match_q   <= 8'd0;
      fail_q    <= 4'd0;
      poly_q    <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      match_q   <= match_d;
      fail_q    <= fail_d;
      poly_q    <= Poly;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign Locked  = (state_q == ST_LOCKED);
  assign Err     = err_q;
  assign Err_cnt = err_cnt_q;
  assign Bit_cnt = bit_cnt_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// -----------------------------------------------------------------------------
// tb_lfsr_checker
//
// Drives two checkers (CW=16 and CW=4) with identical stimulus. A stream-level
// reference model predicts the outputs after every edge and queues them; a
// monitor on the falling edge pops and compares. Directed checks at the key
// points of each scenario use hand-derived constants.
// -----------------------------------------------------------------------------
module tb_lfsr_checker;

  localparam int LOCK_CNT = 7;
  localparam int FAIL_LIM = 3;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        Poly = 1'b0;
  logic        En = 1'b0;
  logic        Din = 1'b0;
  logic        Clr = 1'b0;
  logic        locked16, err16, locked4, err4;
  logic [15:0] ec16, bc16;
  logic [3:0]  ec4, bc4;

  always #5 CLK = ~CLK;

  lfsr_checker #(.LOCK_CNT(LOCK_CNT), .FAIL_LIM(FAIL_LIM), .CW(16)) dut16 (
    .CLK(CLK), .RST(RST), .Poly(Poly), .En(En), .Din(Din), .Clr(Clr),
    .Locked(locked16), .Err(err16), .Err_cnt(ec16), .Bit_cnt(bc16)
  );

  lfsr_checker #(.LOCK_CNT(LOCK_CNT), .FAIL_LIM(FAIL_LIM), .CW(4)) dut4 (
    .CLK(CLK), .RST(RST), .Poly(Poly), .En(En), .Din(Din), .Clr(Clr),
    .Locked(locked4), .Err(err4), .Err_cnt(ec4), .Bit_cnt(bc4)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  // ---------------- reference model (stream level) ----------------
  typedef enum {M_ACQ, M_VERIFY, M_LOCKED} mode_e;
  mode_e m_mode;
  bit    m_hist[$];   // [0] = b[n] oldest, [2] = b[n+2] newest
  int    m_fill, m_match, m_fail;
  bit    m_poly, m_err;
  int    m_errs, m_bits;

  function automatic void m_clear_hist();
    m_hist.delete();
    repeat (3) m_hist.push_back(1'b0);
  endfunction

  function automatic void m_shift(input bit b);
    m_hist.push_back(b);
    void'(m_hist.pop_front());
  endfunction

  function automatic bit m_hist_zero();
    return !(m_hist[0] || m_hist[1] || m_hist[2]);
  endfunction

  function automatic void m_reset();
    m_mode = M_ACQ;
    m_clear_hist();
    m_fill = 0; m_match = 0; m_fail = 0;
    m_poly = 1'b0; m_err = 1'b0;
    m_errs = 0; m_bits = 0;
  endfunction

  function automatic void m_step(input bit rst, input bit en, input bit din,
                                 input bit clr, input bit poly);
    bit p;
    if (!rst) begin
      m_reset();
      return;
    end
    m_err = 1'b0;
    if (poly != m_poly) begin
      m_poly = poly;
      m_mode = M_ACQ;
      m_clear_hist();
      m_fill = 0;
    end else if (en) begin
      p = poly ? (m_hist[1] ^ m_hist[0]) : (m_hist[2] ^ m_hist[0]);
      case (m_mode)
        M_ACQ: begin
          m_shift(din);
          m_fill++;
          if (m_fill == 3) begin
            m_fill = 0;
            if (!m_hist_zero()) begin m_mode = M_VERIFY; m_match = 0; end
          end
        end
        M_VERIFY: begin
          m_shift(din);
          m_match = (din == p) ? m_match + 1 : 0;
          if (m_hist_zero()) begin m_mode = M_ACQ; m_fill = 0; end
          else if (m_match == LOCK_CNT) begin m_mode = M_LOCKED; m_fail = 0; end
        end
        default: begin
          m_shift(p);
          m_bits++;
          if (din != p) begin m_err = 1'b1; m_errs++; m_fail++; end
          else m_fail = 0;
          if (m_fail == FAIL_LIM) begin
            m_mode = M_ACQ; m_clear_hist(); m_fill = 0;
          end
        end
      endcase
    end
    if (clr) begin m_errs = 0; m_bits = 0; end
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic        locked;
    logic        err;
    logic [15:0] ec16;
    logic [15:0] bc16;
    logic [3:0]  ec4;
    logic [3:0]  bc4;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  initial begin
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("mon_locked16", locked16, mon_e.locked);
        check("mon_err16", err16, mon_e.err);
        check("mon_errcnt16", ec16, mon_e.ec16);
        check("mon_bitcnt16", bc16, mon_e.bc16);
        check("mon_locked4", locked4, mon_e.locked);
        check("mon_err4", err4, mon_e.err);
        check("mon_errcnt4", ec4, mon_e.ec4);
        check("mon_bitcnt4", bc4, mon_e.bc4);
      end
    end
  end

  // ---------------- pattern generator ----------------
  bit g[$];
  bit g_poly;

  function automatic void g_seed(input bit [2:0] s, input bit p);
    g.delete();
    g.push_back(s[2]); g.push_back(s[1]); g.push_back(s[0]);
    g_poly = p;
  endfunction

  function automatic bit g_next();
    bit o, nb;
    o  = g[0];
    nb = g_poly ? (g[1] ^ g[0]) : (g[2] ^ g[0]);
    void'(g.pop_front());
    g.push_back(nb);
    return o;
  endfunction

  // ---------------- driver ----------------
  bit poly_drv = 1'b0;
  bit saw_lock, saw_err;

  task automatic step(input bit rst, input bit en, input bit din, input bit clr, input bit poly);
    exp_t e;
    RST = rst; En = en; Din = din; Clr = clr; Poly = poly;
    m_step(rst, en, din, clr, poly);
    e.locked = (m_mode == M_LOCKED);
    e.err    = m_err;
    e.ec16   = 16'(sat(m_errs, 65535));
    e.bc16   = 16'(sat(m_bits, 65535));
    e.ec4    = 4'(sat(m_errs, 15));
    e.bc4    = 4'(sat(m_bits, 15));
    @(posedge CLK);
    exp_q.push_back(e);
    #1;
    if (locked16 === 1'b1) saw_lock = 1'b1;
    if (err16 === 1'b1) saw_err = 1'b1;
  endtask

  task automatic send(input bit b, input bit en = 1'b1, input bit clr = 1'b0);
    step(1'b1, en, b, clr, poly_drv);
  endtask

  task automatic send_gen(input int n);
    repeat (n) send(g_next());
  endtask

  task automatic set_poly(input bit p);
    poly_drv = p;
    send(1'b0, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    bit   en, din, clr;
    int   guard;
    m_reset();

    // Reset state
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset_locked", locked16, 0);
    check("reset_errcnt", ec16, 0);
    send(1'b0, 1'b0);

    // Lock with Poly=0, stream 1110100...
    g_seed(3'b111, 1'b0);
    send_gen(9);
    check("p0_unlocked_bit9", locked16, 0);
    send_gen(1);
    check("p0_locked_bit10", locked16, 1);
    saw_err = 1'b0;
    send_gen(70);
    check("p0_bitcnt70", bc16, 70);
    check("p0_errcnt0", ec16, 0);
    check("p0_no_err", saw_err, 0);

    // Single error, flywheel absorbs it
    send(~g_next());
    check("single_err_pulse", err16, 1);
    check("single_errcnt", ec16, 1);
    check("single_locked", locked16, 1);
    saw_err = 1'b0;
    send_gen(20);
    check("single_no_more_err", saw_err, 0);
    check("single_errcnt_after", ec16, 1);

    // Loss of lock after FAIL_LIM consecutive errors, then relock
    send(g_next(), 1'b1, 1'b1);
    check("clr_errcnt", ec16, 0);
    check("clr_bitcnt", bc16, 0);
    for (int i = 0; i < 3; i++) begin
      send(~g_next());
      check("loss_err_pulse", err16, 1);
      if (i < 2) check("loss_still_locked", locked16, 1);
    end
    check("loss_unlocked", locked16, 0);
    check("loss_errcnt3", ec16, 3);
    send_gen(9);
    check("relock_not_yet", locked16, 0);
    send_gen(1);
    check("relock_bit10", locked16, 1);

    // Saturation: 20 isolated errors
    for (int i = 0; i < 20; i++) begin
      send(~g_next());
      send_gen($urandom_range(1, 4));
    end
    check("sat_errcnt4", ec4, 15);
    check("sat_bitcnt4", bc4, 15);
    check("nosat_errcnt16", ec16, 23);
    send(~g_next(), 1'b1, 1'b1);
    check("clr_with_err_errcnt16", ec16, 0);
    check("clr_with_err_errcnt4", ec4, 0);
    check("clr_with_err_pulse", err16, 1);
    send_gen(2);

    // Asynchronous reset mid-lock
    check("pre_reset_locked", locked16, 1);
    @(negedge CLK);
    #1;
    RST = 1'b0;
    #1;
    check("async_rst_locked", locked16, 0);
    check("async_rst_err", err16, 0);
    check("async_rst_errcnt", ec16, 0);
    check("async_rst_bitcnt", bc16, 0);
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    poly_drv = 1'b0;
    send(1'b0, 1'b0);

    // Lock with Poly=1, stream 1110010...
    set_poly(1'b1);
    g_seed(3'b111, 1'b1);
    send_gen(9);
    check("p1_unlocked_bit9", locked16, 0);
    send_gen(1);
    check("p1_locked_bit10", locked16, 1);
    saw_err = 1'b0;
    send_gen(30);
    check("p1_no_err", saw_err, 0);

    // Poly flip while locked, with En low
    set_poly(1'b0);
    check("poly_flip_unlock", locked16, 0);

    // Poly=1 checker fed a Poly=0 stream never locks
    set_poly(1'b1);
    g_seed(3'($urandom_range(1, 7)), 1'b0);
    saw_lock = 1'b0;
    send_gen(70);
    check("wrong_poly_no_lock", saw_lock, 0);

    // Stuck-at-0 line; 51 bits leaves the fill count at a fresh start
    set_poly(1'b0);
    saw_lock = 1'b0;
    repeat (51) send(1'b0);
    check("stuck0_no_lock", saw_lock, 0);

    // Valid stream with idle gaps
    g_seed(3'($urandom_range(1, 7)), 1'b0);
    for (int v = 1; v <= 10; v++) begin
      send(g_next());
      if (v == 9) check("gap_unlocked_bit9", locked16, 0);
      if (v == 10) check("gap_locked_bit10", locked16, 1);
      repeat ($urandom_range(1, 2)) send(1'($urandom_range(0, 1)), 1'b0);
    end
    check("gap_locked_after_idle", locked16, 1);

    // Randomised soak against the model
    for (int i = 0; i < 400; i++) begin
      en  = ($urandom_range(0, 99) < 80);
      clr = en && ($urandom_range(0, 49) == 0);
      if (!en && $urandom_range(0, 59) == 0) begin
        poly_drv = ~poly_drv;
        g_poly   = poly_drv;
      end
      din = en ? (g_next() ^ ($urandom_range(0, 24) == 0)) : 1'($urandom_range(0, 1));
      send(din, en, clr);
    end

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(negedge CLK);
      guard++;
    end
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
